// File: rtl/control_state_machine.sv
// ---------------------------------------------------------------------------
// control_state_machine
//
// Instruction sequencer for the 8-bit-bus CPU. It walks the 5-bit control
// state that control_signals decodes into datapath strobes. It also inserts
// memory wait states, flags illegal opcodes and halts the core.
//
// Optional build macro:
//   CTRL_SINGLE_STEP_EN - when defined, step_mode_i/step_i gate the start of
//                         each instruction in S_FETCH_1. When undefined, both
//                         inputs are ignored and the core free-runs.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous, active-high reset
//   opcode_i[15:0] IR contents; the class is taken from [15:9]
//   mem_ready_i    memory access completes this cycle when 1
//   step_mode_i    single-step enable (CTRL_SINGLE_STEP_EN builds only)
//   step_i         single-step advance pulse (CTRL_SINGLE_STEP_EN builds only)
//   state_o        current control state, registered
//   instr_done_o   one-cycle pulse on the first S_FETCH_1 cycle after retire
//   halted_o       core stopped (state is S_HALT)
//   illegal_op_o   sticky illegal-opcode flag, cleared only by reset
// ---------------------------------------------------------------------------
module control_state_machine #(
    parameter int STATE_W = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [15:0]        opcode_i,
    input  logic               mem_ready_i,
    input  logic               step_mode_i,
    input  logic               step_i,
    output logic [STATE_W-1:0] state_o,
    output logic               instr_done_o,
    output logic               halted_o,
    output logic               illegal_op_o
);

    typedef enum logic [4:0] {
        S_FETCH_1         = 5'b00000,
        S_FETCH_2         = 5'b00001,
        S_ALU_OPERATION   = 5'b00010,
        S_ALU_IMMEDIATE   = 5'b00011,
        S_STORE_RESULT_1  = 5'b00100,
        S_STORE_RESULT_2  = 5'b00101,
        S_COPY_REGISTER   = 5'b00110,
        S_FETCH_IMMEDIATE = 5'b00111,
        S_FETCH_ADDRESS_1 = 5'b01000,
        S_FETCH_ADDRESS_2 = 5'b01001,
        S_FETCH_ADDRESS_3 = 5'b01010,
        S_FETCH_ADDRESS_4 = 5'b01011,
        S_FETCH_MEMORY    = 5'b01100,
        S_STORE_MEMORY    = 5'b01101,
        S_TEMP_FETCH      = 5'b01110,
        S_TEMP_STORE      = 5'b01111,
        S_LOAD_JUMP_1     = 5'b10000,
        S_LOAD_JUMP_2     = 5'b10001,
        S_EXECUTE_JUMP    = 5'b10010,
        S_HALT            = 5'b11110
    } state_e;

    localparam logic [4:0] OP_MULTIPLY = 5'b00110;
    localparam logic [4:0] OP_MOVE     = 5'b10000;
    localparam logic [4:0] OP_LOAD     = 5'b10001;
    localparam logic [4:0] OP_LOADM    = 5'b10010;
    localparam logic [4:0] OP_STOREM   = 5'b10011;
    localparam logic [4:0] OP_JUMP     = 5'b10100;
    localparam logic [4:0] OP_NOP      = 5'b10101;
    localparam logic [4:0] OP_HALT     = 5'b11111;

    state_e     state_q, state_d;
    logic       instrDone_q, instrDone_d;
    logic       illegalOp_q, illegalOp_d;

    logic [4:0] majorOp;
    logic [1:0] mode;
    state_e     decodeState;
    logic       decodeIllegal;
    state_e     succState;
    logic       succIllegal;
    logic       memState;
    logic       advance;

    // The low opcode bits carry operand fields that belong to the datapath.
    logic       unusedOpcodeBits;
    assign unusedOpcodeBits = ^opcode_i[8:0];

    assign majorOp = opcode_i[15:11];
    assign mode    = opcode_i[10:9];

    // Instruction-class decode, consulted only when leaving S_FETCH_2.
    // ALU class uses the mode field to pick register, immediate or memory
    // operand; MULTIPLY has no memory-operand form.
    always_comb begin
        decodeState   = S_HALT;
        decodeIllegal = 1'b0;
        if (!majorOp[4]) begin
            case (mode)
                2'b00: decodeState = S_ALU_OPERATION;
                2'b01: decodeState = S_ALU_IMMEDIATE;
                2'b10: begin
                    if (majorOp == OP_MULTIPLY) begin
                        decodeIllegal = 1'b1;
                    end else begin
                        decodeState = S_FETCH_ADDRESS_3;
                    end
                end
                default: decodeIllegal = 1'b1;
            endcase
        end else begin
            case (majorOp)
                OP_MOVE:   decodeState = S_COPY_REGISTER;
                OP_LOAD:   decodeState = S_FETCH_IMMEDIATE;
                OP_LOADM:  decodeState = S_FETCH_ADDRESS_1;
                OP_STOREM: decodeState = S_FETCH_ADDRESS_1;
                OP_JUMP:   decodeState = S_LOAD_JUMP_1;
                OP_NOP:    decodeState = S_FETCH_1;
                OP_HALT:   decodeState = S_HALT;
                default:   decodeIllegal = 1'b1;
            endcase
        end
    end

    // Successor of each state, plus whether the state waits on mem_ready_i.
    // The IR is stable for the whole instruction, so later states may look
    // at the major code again (MULTIPLY tail, LOADM vs STOREM split).
    always_comb begin
        succState   = S_HALT;
        succIllegal = 1'b0;
        memState    = 1'b0;
        case (state_q)
            S_FETCH_1: begin
                memState  = 1'b1;
                succState = S_FETCH_2;
            end
            S_FETCH_2: begin
                memState    = 1'b1;
                succState   = decodeState;
                succIllegal = decodeIllegal;
            end
            S_ALU_OPERATION: succState = S_STORE_RESULT_1;
            S_ALU_IMMEDIATE: begin
                memState  = 1'b1;
                succState = S_STORE_RESULT_1;
            end
            S_STORE_RESULT_1: begin
                succState = (majorOp == OP_MULTIPLY) ? S_STORE_RESULT_2 : S_FETCH_1;
            end
            S_STORE_RESULT_2: succState = S_FETCH_1;
            S_COPY_REGISTER:  succState = S_FETCH_1;
            S_FETCH_IMMEDIATE: begin
                memState  = 1'b1;
                succState = S_FETCH_1;
            end
            S_FETCH_ADDRESS_1: begin
                memState  = 1'b1;
                succState = S_FETCH_ADDRESS_2;
            end
            S_FETCH_ADDRESS_2: begin
                memState  = 1'b1;
                succState = majorOp[0] ? S_STORE_MEMORY : S_FETCH_MEMORY;
            end
            S_FETCH_ADDRESS_3: begin
                memState  = 1'b1;
                succState = S_FETCH_ADDRESS_4;
            end
            S_FETCH_ADDRESS_4: begin
                memState  = 1'b1;
                succState = S_TEMP_FETCH;
            end
            S_FETCH_MEMORY, S_STORE_MEMORY, S_TEMP_STORE: begin
                memState  = 1'b1;
                succState = S_FETCH_1;
            end
            S_TEMP_FETCH: begin
                memState  = 1'b1;
                succState = S_TEMP_STORE;
            end
            S_LOAD_JUMP_1: begin
                memState  = 1'b1;
                succState = S_LOAD_JUMP_2;
            end
            S_LOAD_JUMP_2: begin
                memState  = 1'b1;
                succState = S_EXECUTE_JUMP;
            end
            S_EXECUTE_JUMP: succState = S_FETCH_1;
            S_HALT:         succState = S_HALT;
            default: begin
                succState   = S_HALT;
                succIllegal = 1'b1;
            end
        endcase
    end

`ifdef CTRL_SINGLE_STEP_EN
    // stepArmed_q remembers a step pulse accepted in S_FETCH_1, so a memory
    // stall after the pulse does not lose it. It drops once the instruction
    // leaves S_FETCH_1, which is why mid-instruction pulses have no effect.
    logic stepArmed_q, stepArmed_d;
    logic stepHold;

    always_comb begin
        stepArmed_d = 1'b0;
        if (state_q == S_FETCH_1) begin
            stepArmed_d = stepArmed_q | (step_mode_i & step_i);
        end
        stepHold = (state_q == S_FETCH_1) && step_mode_i && !step_i && !stepArmed_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stepArmed_q <= 1'b0;
        end else begin
            stepArmed_q <= stepArmed_d;
        end
    end
`else
    logic stepHold;
    logic unusedStepInputs;
    assign stepHold         = 1'b0;
    assign unusedStepInputs = step_mode_i ^ step_i;
`endif

    // Memory states stall while mem_ready_i is low; everything else moves on.
    // instr_done is raised for the cycle after any transition that lands in
    // S_FETCH_1 from another state, so stalls in S_FETCH_1 never repeat it.
    always_comb begin
        advance     = (!memState || mem_ready_i) && !stepHold;
        state_d     = advance ? succState : state_q;
        illegalOp_d = illegalOp_q | (advance & succIllegal);
        instrDone_d = (state_q != S_FETCH_1) && (state_d == S_FETCH_1);
    end

    // State and flag registers; reset wins over everything, including S_HALT.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_FETCH_1;
            instrDone_q <= 1'b0;
            illegalOp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instrDone_q <= instrDone_d;
            illegalOp_q <= illegalOp_d;
        end
    end

    assign state_o      = STATE_W'(state_q);
    assign instr_done_o = instrDone_q;
    assign halted_o     = (state_q == S_HALT);
    assign illegal_op_o = illegalOp_q;

endmodule
